// File: rtl/writeback_arbiter.sv
// Write-port arbiter for the integer register file: merges load and ALU
// results, extends loads, drops x0 writes and flags pending writes to decode.
module writeback_arbiter #(
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          ALU_V,
    input  logic [4:0]    ALU_DR,
    input  logic [63:0]   ALU_DATA,
    output logic          ALU_READY,
    input  logic          MEM_V,
    input  logic [4:0]    MEM_DR,
    input  logic [63:0]   MEM_DATA,
    input  logic [1:0]    MEM_SIZE,
    input  logic          MEM_UNSIGNED,
    input  logic [4:0]    QUERY_SR1,
    input  logic [4:0]    QUERY_SR2,
    output logic          PEND_HIT1,
    output logic          PEND_HIT2,
    output logic [4:0]    DR,
    output logic [63:0]   WB_DATA,
    output logic          WB_LD_REG,
    output logic [CW-1:0] FIFO_COUNT
);

    logic [4:0]    fifo_dr   [FIFO_DEPTH];
    logic [63:0]   fifo_data [FIFO_DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;

    logic          fifo_empty;
    logic          alu_acc;
    logic          sel_mem;
    logic          sel_fifo;
    logic          sel_alu;
    logic          enq;
    logic          deq;
    logic [4:0]    sel_dr;
    logic [63:0]   sel_data;
    logic [63:0]   load_ext;
    logic [FIFO_DEPTH-1:0] entry_valid;

    assign fifo_empty = (count == '0);
    assign ALU_READY  = (count < CW'(FIFO_DEPTH));
    assign alu_acc    = ALU_V & ALU_READY;

    assign sel_mem  = MEM_V;
    assign sel_fifo = ~MEM_V & ~fifo_empty;
    assign sel_alu  = ~MEM_V & fifo_empty & alu_acc;

    // Bypass only when nothing older is queued, so ALU order is preserved
    assign enq = alu_acc & ~sel_alu;
    assign deq = sel_fifo;

    always_comb begin
        load_ext = MEM_DATA;
        unique case (MEM_SIZE)
            2'd0: load_ext = {{56{~MEM_UNSIGNED & MEM_DATA[7]}}, MEM_DATA[7:0]};
            2'd1: load_ext = {{48{~MEM_UNSIGNED & MEM_DATA[15]}}, MEM_DATA[15:0]};
            2'd2: load_ext = {{32{~MEM_UNSIGNED & MEM_DATA[31]}}, MEM_DATA[31:0]};
            2'd3: load_ext = MEM_DATA;
        endcase
    end

    always_comb begin
        sel_dr   = ALU_DR;
        sel_data = ALU_DATA;
        if (sel_mem) begin
            sel_dr   = MEM_DR;
            sel_data = load_ext;
        end else if (sel_fifo) begin
            sel_dr   = fifo_dr[head];
            sel_data = fifo_data[head];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DR        <= '0;
            WB_DATA   <= '0;
            WB_LD_REG <= 1'b0;
        end else if (sel_mem | sel_fifo | sel_alu) begin
            DR        <= sel_dr;
            WB_DATA   <= sel_data;
            WB_LD_REG <= (sel_dr != 5'd0);
        end else begin
            WB_LD_REG <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_dr[i]   <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            if (enq) begin
                fifo_dr[tail]   <= ALU_DR;
                fifo_data[tail] <= ALU_DATA;
                tail            <= tail + 1'b1;
            end
            if (deq) begin
                head <= head + 1'b1;
            end
            if (enq & ~deq) begin
                count <= count + 1'b1;
            end else if (deq & ~enq) begin
                count <= count - 1'b1;
            end
        end
    end

    assign FIFO_COUNT = count;

    // An entry is live when its distance from head is below the count
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            entry_valid[i] = ({1'b0, AW'(AW'(i) - head)} < count);
        end
    end

    function automatic logic pend_hit(input logic [4:0] q);
        logic hit;
        hit = 1'b0;
        if (WB_LD_REG && DR == q) hit = 1'b1;
        if (alu_acc && ALU_DR == q) hit = 1'b1;
        if (MEM_V && MEM_DR == q) hit = 1'b1;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i] && fifo_dr[i] == q) hit = 1'b1;
        end
        return hit && (q != 5'd0);
    endfunction

    assign PEND_HIT1 = pend_hit(QUERY_SR1);
    assign PEND_HIT2 = pend_hit(QUERY_SR2);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: bypass, collision, load extension,
// backpressure with pointer wrap, x0 suppression, hazards and reset.
module tb_writeback_arbiter;

    logic        CLK;
    logic        RST_N;
    logic        ALU_V;
    logic [4:0]  ALU_DR;
    logic [63:0] ALU_DATA;
    logic        ALU_READY;
    logic        MEM_V;
    logic [4:0]  MEM_DR;
    logic [63:0] MEM_DATA;
    logic [1:0]  MEM_SIZE;
    logic        MEM_UNSIGNED;
    logic [4:0]  QUERY_SR1;
    logic [4:0]  QUERY_SR2;
    logic        PEND_HIT1;
    logic        PEND_HIT2;
    logic [4:0]  DR;
    logic [63:0] WB_DATA;
    logic        WB_LD_REG;
    logic [2:0]  FIFO_COUNT;

    int checks = 0;
    int errors = 0;

    writeback_arbiter #(.FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .ALU_V(ALU_V), .ALU_DR(ALU_DR), .ALU_DATA(ALU_DATA),
        .ALU_READY(ALU_READY),
        .MEM_V(MEM_V), .MEM_DR(MEM_DR), .MEM_DATA(MEM_DATA),
        .MEM_SIZE(MEM_SIZE), .MEM_UNSIGNED(MEM_UNSIGNED),
        .QUERY_SR1(QUERY_SR1), .QUERY_SR2(QUERY_SR2),
        .PEND_HIT1(PEND_HIT1), .PEND_HIT2(PEND_HIT2),
        .DR(DR), .WB_DATA(WB_DATA), .WB_LD_REG(WB_LD_REG),
        .FIFO_COUNT(FIFO_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ALU_V = 0; ALU_DR = 0; ALU_DATA = 0;
        MEM_V = 0; MEM_DR = 0; MEM_DATA = 0;
        MEM_SIZE = 2'd3; MEM_UNSIGNED = 0;
        QUERY_SR1 = 0; QUERY_SR2 = 0;
    endtask

    task automatic test_reset();
        RST_N = 0;
        idle_inputs();
        #12;
        checks++; if (WB_LD_REG !== 1'b0) begin errors++; $display("FAIL rst_ld got %0b exp 0", WB_LD_REG); end
        checks++; if (DR !== 5'd0) begin errors++; $display("FAIL rst_dr got %0d exp 0", DR); end
        checks++; if (WB_DATA !== 64'd0) begin errors++; $display("FAIL rst_data got %h exp 0", WB_DATA); end
        checks++; if (FIFO_COUNT !== 3'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", FIFO_COUNT); end
        checks++; if (ALU_READY !== 1'b1) begin errors++; $display("FAIL rst_rdy got %0b exp 1", ALU_READY); end
        @(negedge CLK);
        RST_N = 1;
        step();
    endtask

    task automatic test_bypass();
        ALU_V = 1; ALU_DR = 5; ALU_DATA = 64'h1234;
        step();
        ALU_V = 0;
        checks++; if (WB_LD_REG !== 1'b1) begin errors++; $display("FAIL byp_ld got %0b exp 1", WB_LD_REG); end
        checks++; if (DR !== 5'd5) begin errors++; $display("FAIL byp_dr got %0d exp 5", DR); end
        checks++; if (WB_DATA !== 64'h1234) begin errors++; $display("FAIL byp_data got %h exp 1234", WB_DATA); end
        checks++; if (FIFO_COUNT !== 3'd0) begin errors++; $display("FAIL byp_cnt got %0d exp 0", FIFO_COUNT); end
        step();
        checks++; if (WB_LD_REG !== 1'b0) begin errors++; $display("FAIL byp_idle_ld got %0b exp 0", WB_LD_REG); end
        checks++; if (DR !== 5'd5 || WB_DATA !== 64'h1234) begin errors++; $display("FAIL byp_hold got %0d/%h exp 5/1234", DR, WB_DATA); end
    endtask

    task automatic test_collision();
        MEM_V = 1; MEM_DR = 3; MEM_DATA = 64'h55; MEM_SIZE = 2'd3;
        ALU_V = 1; ALU_DR = 4; ALU_DATA = 64'hAA;
        step();
        MEM_V = 0; ALU_V = 0;
        checks++; if (DR !== 5'd3 || WB_DATA !== 64'h55 || WB_LD_REG !== 1'b1) begin errors++; $display("FAIL col_mem got %0d/%h/%0b exp 3/55/1", DR, WB_DATA, WB_LD_REG); end
        checks++; if (FIFO_COUNT !== 3'd1) begin errors++; $display("FAIL col_cnt got %0d exp 1", FIFO_COUNT); end
        step();
        checks++; if (DR !== 5'd4 || WB_DATA !== 64'hAA || WB_LD_REG !== 1'b1) begin errors++; $display("FAIL col_alu got %0d/%h/%0b exp 4/aa/1", DR, WB_DATA, WB_LD_REG); end
        checks++; if (FIFO_COUNT !== 3'd0) begin errors++; $display("FAIL col_cnt2 got %0d exp 0", FIFO_COUNT); end
    endtask

    task automatic test_load_ext();
        logic [63:0] din [5];
        logic [1:0]  sz  [5];
        logic        un  [5];
        logic [63:0] exp [5];
        din[0] = 64'h80;                 sz[0] = 0; un[0] = 0; exp[0] = 64'hFFFFFFFFFFFFFF80;
        din[1] = 64'h80;                 sz[1] = 0; un[1] = 1; exp[1] = 64'h80;
        din[2] = 64'h0000000080000000;   sz[2] = 2; un[2] = 0; exp[2] = 64'hFFFFFFFF80000000;
        din[3] = 64'h0000000012348001;   sz[3] = 1; un[3] = 0; exp[3] = 64'hFFFFFFFFFFFF8001;
        din[4] = 64'h8000000000000001;   sz[4] = 3; un[4] = 1; exp[4] = 64'h8000000000000001;
        for (int i = 0; i < 5; i++) begin
            MEM_V = 1; MEM_DR = 6; MEM_DATA = din[i];
            MEM_SIZE = sz[i]; MEM_UNSIGNED = un[i];
            step();
            checks++; if (WB_DATA !== exp[i] || WB_LD_REG !== 1'b1) begin errors++; $display("FAIL ldext_%0d got %h/%0b exp %h/1", i, WB_DATA, WB_LD_REG, exp[i]); end
        end
        MEM_V = 0; MEM_SIZE = 2'd3; MEM_UNSIGNED = 0;
    endtask

    task automatic test_backpressure();
        int idx = 0;
        logic acc;
        MEM_V = 1; MEM_DR = 1; MEM_DATA = 64'h77; ALU_V = 1;
        for (int k = 0; k < 6; k++) begin
            ALU_DR = 5'(10 + idx); ALU_DATA = 64'h100 + 64'(idx);
            checks++; if (ALU_READY !== (k < 4)) begin errors++; $display("FAIL bp_rdy_%0d got %0b exp %0b", k, ALU_READY, (k < 4)); end
            acc = ALU_READY;
            step();
            if (acc) idx++;
        end
        checks++; if (FIFO_COUNT !== 3'd4) begin errors++; $display("FAIL bp_cnt got %0d exp 4", FIFO_COUNT); end
        checks++; if (DR !== 5'd1 || WB_DATA !== 64'h77) begin errors++; $display("FAIL bp_mem got %0d/%h exp 1/77", DR, WB_DATA); end
        MEM_V = 0; ALU_V = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (DR !== 5'(10 + i) || WB_DATA !== 64'h100 + 64'(i) || WB_LD_REG !== 1'b1) begin errors++; $display("FAIL bp_drain_%0d got %0d/%h exp %0d/%h", i, DR, WB_DATA, 10 + i, 64'h100 + 64'(i)); end
        end
        checks++; if (FIFO_COUNT !== 3'd0) begin errors++; $display("FAIL bp_empty got %0d exp 0", FIFO_COUNT); end
        MEM_V = 1; MEM_DR = 1;
        for (int j = 0; j < 3; j++) begin
            ALU_V = 1; ALU_DR = 5'(20 + j); ALU_DATA = 64'h200 + 64'(j);
            step();
        end
        MEM_V = 0;
        for (int j = 0; j < 5; j++) begin
            if (j < 2) begin
                ALU_V = 1; ALU_DR = 5'(23 + j); ALU_DATA = 64'h203 + 64'(j);
            end else begin
                ALU_V = 0;
            end
            step();
            checks++; if (DR !== 5'(20 + j) || WB_DATA !== 64'h200 + 64'(j)) begin errors++; $display("FAIL wrap_%0d got %0d/%h exp %0d/%h", j, DR, WB_DATA, 20 + j, 64'h200 + 64'(j)); end
        end
        checks++; if (FIFO_COUNT !== 3'd0) begin errors++; $display("FAIL wrap_cnt got %0d exp 0", FIFO_COUNT); end
    endtask

    task automatic test_x0();
        ALU_V = 1; ALU_DR = 0; ALU_DATA = 64'h99;
        step();
        ALU_V = 0;
        checks++; if (WB_LD_REG !== 1'b0) begin errors++; $display("FAIL x0_alu got %0b exp 0", WB_LD_REG); end
        checks++; if (FIFO_COUNT !== 3'd0) begin errors++; $display("FAIL x0_cnt got %0d exp 0", FIFO_COUNT); end
        MEM_V = 1; MEM_DR = 0; MEM_DATA = 64'h5;
        ALU_V = 1; ALU_DR = 0; ALU_DATA = 64'h6;
        step();
        MEM_V = 0; ALU_V = 0;
        checks++; if (WB_LD_REG !== 1'b0) begin errors++; $display("FAIL x0_mem got %0b exp 0", WB_LD_REG); end
        checks++; if (FIFO_COUNT !== 3'd1) begin errors++; $display("FAIL x0_q got %0d exp 1", FIFO_COUNT); end
        step();
        checks++; if (WB_LD_REG !== 1'b0 || FIFO_COUNT !== 3'd0) begin errors++; $display("FAIL x0_deq got %0b/%0d exp 0/0", WB_LD_REG, FIFO_COUNT); end
    endtask

    task automatic test_hazard();
        MEM_V = 1; MEM_DR = 2; MEM_DATA = 64'h1;
        ALU_V = 1; ALU_DR = 7; ALU_DATA = 64'h2;
        step();
        MEM_V = 0; ALU_V = 0;
        QUERY_SR1 = 7; QUERY_SR2 = 2;
        #1;
        checks++; if (PEND_HIT1 !== 1'b1) begin errors++; $display("FAIL hz_fifo got %0b exp 1", PEND_HIT1); end
        checks++; if (PEND_HIT2 !== 1'b1) begin errors++; $display("FAIL hz_wb got %0b exp 1", PEND_HIT2); end
        QUERY_SR2 = 9;
        #1;
        checks++; if (PEND_HIT2 !== 1'b0) begin errors++; $display("FAIL hz_miss got %0b exp 0", PEND_HIT2); end
        ALU_V = 1; ALU_DR = 12; QUERY_SR2 = 12;
        #1;
        checks++; if (PEND_HIT2 !== 1'b1) begin errors++; $display("FAIL hz_alu got %0b exp 1", PEND_HIT2); end
        ALU_V = 0; MEM_V = 1; MEM_DR = 13; QUERY_SR2 = 13;
        #1;
        checks++; if (PEND_HIT2 !== 1'b1) begin errors++; $display("FAIL hz_mem got %0b exp 1", PEND_HIT2); end
        MEM_V = 0; ALU_V = 1; ALU_DR = 0; QUERY_SR1 = 0;
        #1;
        checks++; if (PEND_HIT1 !== 1'b0) begin errors++; $display("FAIL hz_zero got %0b exp 0", PEND_HIT1); end
        ALU_V = 0; QUERY_SR1 = 7;
        step();
        checks++; if (DR !== 5'd7 || WB_LD_REG !== 1'b1) begin errors++; $display("FAIL hz_drain got %0d/%0b exp 7/1", DR, WB_LD_REG); end
        step();
        checks++; if (PEND_HIT1 !== 1'b0) begin errors++; $display("FAIL hz_clear got %0b exp 0", PEND_HIT1); end
        QUERY_SR1 = 0; QUERY_SR2 = 0;
    endtask

    task automatic test_reset_mid();
        MEM_V = 1; MEM_DR = 3; MEM_DATA = 64'h33;
        for (int j = 0; j < 3; j++) begin
            ALU_V = 1; ALU_DR = 5'(25 + j); ALU_DATA = 64'h300 + 64'(j);
            step();
        end
        checks++; if (FIFO_COUNT !== 3'd3) begin errors++; $display("FAIL rm_fill got %0d exp 3", FIFO_COUNT); end
        #2;
        RST_N = 0;
        #1;
        checks++; if (FIFO_COUNT !== 3'd0) begin errors++; $display("FAIL rm_cnt got %0d exp 0", FIFO_COUNT); end
        checks++; if (WB_LD_REG !== 1'b0 || DR !== 5'd0) begin errors++; $display("FAIL rm_out got %0b/%0d exp 0/0", WB_LD_REG, DR); end
        MEM_V = 0; ALU_V = 0;
        @(negedge CLK);
        RST_N = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (WB_LD_REG !== 1'b0 || FIFO_COUNT !== 3'd0) begin errors++; $display("FAIL rm_stale_%0d got %0b/%0d exp 0/0", k, WB_LD_REG, FIFO_COUNT); end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_collision();
        test_load_ext();
        test_backpressure();
        test_x0();
        test_hazard();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writer side of the 64-bit, 32-entry integer register file's single write port.
- Accepts completed results from two producers and serialises them onto DR/WB_DATA/WB_LD_REG, one write per cycle:
  - ALU: single-cycle results, stallable.
  - MEM: load data, not stallable.
- Performs load sign/zero extension, suppresses x0 writes, and buffers ALU results in a small FIFO when a load collides.
- Reports pending-write hazards to decode.

Parameters:
FIFO_DEPTH, 4, ALU result buffer entries (power of two, >=2)

Ports:
CLK  input  1  clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
ALU_V  input  1  ALU result valid
ALU_DR  input  5  ALU destination register
ALU_DATA  input  64  ALU result
ALU_READY  output  1  ALU result accepted this cycle when ALU_V=1
MEM_V  input  1  load result valid (always accepted)
MEM_DR  input  5  load destination register
MEM_DATA  input  64  raw load data, right-aligned
MEM_SIZE  input  2  0=byte 1=half 2=word 3=double
MEM_UNSIGNED  input  1  1=zero-extend, 0=sign-extend
QUERY_SR1  input  5  decode source 1
QUERY_SR2  input  5  decode source 2
PEND_HIT1  output  1  QUERY_SR1 has an uncommitted write
PEND_HIT2  output  1  QUERY_SR2 has an uncommitted write
DR  output  5  register-file write address
WB_DATA  output  64  register-file write data
WB_LD_REG  output  1  register-file write enable
FIFO_COUNT  output  log2(FIFO_DEPTH)+1  occupied ALU FIFO entries

Behaviour:
- Reset (RST_N low, async): WB_LD_REG=0, DR=0, WB_DATA=0, FIFO empty, FIFO_COUNT=0, pointers=0. Buffered results are discarded, including on reset mid-operation.
- DR/WB_DATA/WB_LD_REG are registered. A result selected in cycle N appears in cycle N+1, and the register file commits at the end of cycle N+1.
- Per-cycle selection, in priority order:
  1. MEM_V=1: the load is selected.
  2. Else FIFO non-empty: the FIFO head is selected and dequeued.
  3. Else ALU_V=1: the ALU input is selected directly (bypass, latency 1).
  4. Else WB_LD_REG=0 next cycle; DR and WB_DATA hold their previous values.
- ALU_READY=1 iff FIFO_COUNT<FIFO_DEPTH. It is computed from the registered count only; no same-cycle dequeue credit. It does not depend on ALU_V.
- An accepted ALU result that is not bypassed is enqueued at the tail. Bypass is allowed only when the FIFO is empty and MEM_V=0, so ALU results commit in acceptance order.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. Pointers wrap modulo FIFO_DEPTH.
- ALU_V=1 with ALU_READY=0: no state change. The producer must hold its inputs.
- Load extension: take the low 8/16/32/64 bits per MEM_SIZE, then sign- or zero-extend to 64 bits. MEM_SIZE=3 passes the data through unchanged, regardless of MEM_UNSIGNED.
- x0: a selected result with destination 0 is consumed normally (dequeued or accepted), but WB_LD_REG stays 0 for that cycle.
- PEND_HIT (combinational), per query: 1 iff the query is non-zero and matches any of:
  - DR while WB_LD_REG=1
  - any valid FIFO entry's DR
  - ALU_DR while ALU_V&ALU_READY
  - MEM_DR while MEM_V

  Otherwise 0.
- WB_DATA is not forwarded; the hit signals are for stall only.

Test Plan:
- Reset mid-stream: fill FIFO with 3 entries, assert RST_N=0 -> immediately FIFO_COUNT=0, WB_LD_REG=0. After release, no stale writes appear.
- ALU bypass: ALU_V=1, DR=5, DATA=0x1234, idle otherwise -> next cycle WB_LD_REG=1, DR=5, WB_DATA=0x1234.
- Collision: MEM_V=1 and ALU_V=1 in the same cycle -> the load commits in cycle N+1, the ALU result in N+2, and FIFO_COUNT reads 1 during N+1.
- Load extension:
  - MEM_DATA=0x80, SIZE=0, UNSIGNED=0 -> WB_DATA=0xFFFFFFFFFFFFFF80.
  - Same with UNSIGNED=1 -> 0x80.
  - MEM_DATA=0x00000000_8000_0000, SIZE=2, signed -> 0xFFFFFFFF80000000.
- Backpressure/wrap: hold MEM_V=1 for 6 cycles with ALU_V=1 -> ALU_READY drops after 4 accepts. After MEM_V drops, the 4 results drain in order, then further accepts wrap the pointers with data intact.
- x0 and hazard:
  - ALU result to DR=0 -> WB_LD_REG never asserts.
  - FIFO holding DR=7 with QUERY_SR1=7 -> PEND_HIT1=1.
  - QUERY_SR1=0 -> PEND_HIT1=0 always.
